// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests and
// buffers responses for decode. Define FETCH_PERF_EN to enable the taken-redirect counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        do_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] redirect_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    // RUN: responses are pushed; DRAIN: wrong-path responses are still owed and get dropped.
    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];

    logic          redirect;
    logic [31:0]   target_aligned;
    logic [CW:0]   credit_used;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] discard_nxt;
    logic [CW-1:0] fifo_count_nxt;

    wire unused_target_lsbs = &{1'b0, branch_target[1:0]};

    assign redirect       = ex_valid & do_branch;
    assign target_aligned = {branch_target[31:2], 2'b00};
    assign fifo_empty     = (fifo_count == '0);

    // Every accepted request owns a FIFO slot, so pushes can never overflow.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = ~rst & ~redirect & (credit_used < CREDITS);
    assign imem_req_addr  = rst ? RESET_PC : pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign drop = imem_rsp_valid & (redirect | (state == ST_DRAIN));
    assign push = imem_rsp_valid & ~drop;

    assign out_valid = ~rst & ~fifo_empty & ~redirect;
    assign pop       = out_valid & out_ready;
    assign out_instr = (rst | fifo_empty) ? 32'h0 : fifo_instr[rd_ptr];
    assign out_pc    = (rst | fifo_empty) ? 32'h0 : fifo_pc[rd_ptr];

    always_comb begin
        inflight_nxt   = inflight + CW'(accept) - CW'(imem_rsp_valid);
        discard_nxt    = discard;
        fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
        if (redirect) begin
            // Everything still owed is wrong-path; a response arriving now is dropped directly.
            discard_nxt    = inflight - CW'(imem_rsp_valid);
            fifo_count_nxt = '0;
        end else if (imem_rsp_valid && (discard != '0)) begin
            discard_nxt = discard - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            rsp_pc     <= RESET_PC;
            inflight   <= '0;
            discard    <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= (discard_nxt != '0) ? ST_DRAIN : ST_RUN;
            inflight   <= inflight_nxt;
            discard    <= discard_nxt;
            fifo_count <= fifo_count_nxt;
            if (redirect) begin
                pc     <= target_aligned;
                rsp_pc <= target_aligned;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= 32'h0;
        end else if (redirect) begin
            redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

    assign redirect_count = redirect_cnt;
`else
    assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable imem, an address-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        do_branch;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] redirect_count;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .do_branch(do_branch),
        .branch_target(branch_target), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect_count(redirect_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // ---------------- imem model ----------------
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] m_pc;
    logic [31:0] m_fl_addr[$];
    bit          m_fl_kill[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] m_redirects;
    logic [31:0] xfer_pc[$];
    logic [31:0] xfer_instr[$];
    int          req_cnt = 0;

    always @(negedge clk) begin
        logic        e_redirect;
        logic        e_req;
        logic        e_out;
        logic [31:0] a;
        bit          k;
        e_redirect = ex_valid & do_branch;
        if (rst) begin
            check32("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
            check32("rst_out_valid", {31'b0, out_valid}, 32'h0);
            m_pc = RESET_PC;
            m_redirects = 32'h0;
            m_fl_addr.delete();
            m_fl_kill.delete();
            exp_q.delete();
            exp_instr_q.delete();
            pend_addr.delete();
            pend_due.delete();
        end else begin
            e_req = !e_redirect && ((m_fl_addr.size() + exp_q.size()) < DEPTH);
            e_out = !e_redirect && (exp_q.size() > 0);
            check32("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
            check32("req_addr", imem_req_addr, m_pc);
            check32("out_valid", {31'b0, out_valid}, {31'b0, e_out});
            if (e_out) begin
                check32("out_pc", out_pc, exp_q[0]);
                check32("out_instr", out_instr, exp_instr_q[0]);
            end
            check32("redirect_count", redirect_count, PERF ? m_redirects : 32'h0);

            // imem sees the DUT's actual requests; logs record actual transfers
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                req_cnt++;
            end
            if (imem_rsp_valid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (out_valid && out_ready) begin
                xfer_pc.push_back(out_pc);
                xfer_instr.push_back(out_instr);
            end

            if (e_redirect) begin
                m_redirects = m_redirects + 32'd1;
                foreach (m_fl_kill[i]) m_fl_kill[i] = 1'b1;
                if (imem_rsp_valid && m_fl_addr.size() > 0) begin
                    void'(m_fl_addr.pop_front());
                    void'(m_fl_kill.pop_front());
                end
                exp_q.delete();
                exp_instr_q.delete();
                m_pc = {branch_target[31:2], 2'b00};
            end else begin
                if (e_out && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_instr_q.pop_front());
                end
                if (imem_rsp_valid && m_fl_addr.size() > 0) begin
                    a = m_fl_addr.pop_front();
                    k = m_fl_kill.pop_front();
                    if (!k) begin
                        exp_q.push_back(a);
                        exp_instr_q.push_back(mem_word(a));
                    end
                end
                if (e_req && imem_req_ready) begin
                    m_fl_addr.push_back(m_pc);
                    m_fl_kill.push_back(1'b0);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_xfer(string name, int want, int budget);
        int n;
        n = 0;
        while (xfer_pc.size() < want && n < budget) begin
            tick();
            n++;
        end
        if (xfer_pc.size() < want) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d transfers expected %0d within %0d cycles", name,
                     xfer_pc.size(), want, budget);
        end
    endtask

    task automatic set_redirect(logic [31:0] tgt);
        ex_valid      = 1'b1;
        do_branch     = 1'b1;
        branch_target = tgt;
    endtask

    task automatic clr_redirect();
        ex_valid  = 1'b0;
        do_branch = 1'b0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bit found;
        rst = 1'b1;
        ex_valid = 1'b0;
        do_branch = 1'b0;
        branch_target = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        out_ready = 1'b1;
        repeat (3) tick();

        // 1: streaming after reset, 1-cycle imem
        rst = 1'b0;
        xfer_pc.delete();
        xfer_instr.delete();
        @(negedge clk);
        check32("t1_reset_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check32("t1_reset_addr", imem_req_addr, 32'h0);
        check32("t1_reset_out_valid", {31'b0, out_valid}, 32'h0);
        check32("t1_reset_out_pc", out_pc, 32'h0);
        check32("t1_reset_count", redirect_count, 32'h0);
        tick();
        @(negedge clk);
        check32("t1_c1_out_valid", {31'b0, out_valid}, 32'h0);
        tick();
        @(negedge clk);
        check32("t1_c2_out_valid", {31'b0, out_valid}, 32'h1);
        check32("t1_c2_out_pc", out_pc, 32'h0);
        check32("t1_c2_out_instr", out_instr, 32'hDEAD_0000);
        wait_xfer("t1_stream", 4, 40);
        if (xfer_pc.size() >= 4) begin
            check32("t1_xfer1", xfer_pc[1], 32'h4);
            check32("t1_xfer2", xfer_pc[2], 32'h8);
            check32("t1_xfer3", xfer_pc[3], 32'hC);
            check32("t1_instr3", xfer_instr[3], 32'hDEAD_000C);
        end

        // 2: decode stalled -> only DEPTH requests
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        req_cnt = 0;
        repeat (10) tick();
        @(negedge clk);
        check32("t2_req_cnt", req_cnt, 32'd2);
        check32("t2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check32("t2_out_valid", {31'b0, out_valid}, 32'h1);
        check32("t2_out_pc", out_pc, 32'h0);
        check32("t2_out_instr", out_instr, 32'hDEAD_0000);

        // 3: redirect with 8 and 12 in flight
        tick();
        lat = 3;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_fl_addr.size() == 2 && exp_q.size() == 0) found = 1'b1;
        end
        check32("t3_setup_found", {31'b0, found}, 32'h1);
        if (found) begin
            check32("t3_inflight0", m_fl_addr[0], 32'h8);
            check32("t3_inflight1", m_fl_addr[1], 32'hC);
        end
        xfer_pc.delete();
        xfer_instr.delete();
        set_redirect(32'h0000_0103);
        tick();
        clr_redirect();
        wait_xfer("t3_after_redirect", 1, 40);
        if (xfer_pc.size() >= 1) begin
            check32("t3_first_pc", xfer_pc[0], 32'h100);
            check32("t3_first_instr", xfer_instr[0], 32'hDEAD_0100);
        end

        // 4: redirect while a response arrives and the FIFO holds data
        tick();
        lat = 1;
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (imem_rsp_valid && exp_q.size() > 0) found = 1'b1;
        end
        check32("t4_setup_found", {31'b0, found}, 32'h1);
        xfer_pc.delete();
        xfer_instr.delete();
        set_redirect(32'h200);
        @(negedge clk);
        check32("t4_redirect_out_valid", {31'b0, out_valid}, 32'h0);
        tick();
        clr_redirect();
        @(negedge clk);
        check32("t4_flushed_out_valid", {31'b0, out_valid}, 32'h0);
        tick();
        out_ready = 1'b1;
        wait_xfer("t4_after_redirect", 1, 40);
        if (xfer_pc.size() >= 1) check32("t4_first_pc", xfer_pc[0], 32'h200);

        // 5: back-to-back redirects, latest wins
        tick();
        xfer_pc.delete();
        xfer_instr.delete();
        set_redirect(32'h40);
        tick();
        set_redirect(32'h80);
        tick();
        clr_redirect();
        wait_xfer("t5_after_redirect", 2, 40);
        if (xfer_pc.size() >= 2) begin
            check32("t5_first_pc", xfer_pc[0], 32'h80);
            check32("t5_first_instr", xfer_instr[0], 32'hDEAD_0080);
            check32("t5_second_pc", xfer_pc[1], 32'h84);
        end

        // 6: redirect counter, then reset in the middle of a drain
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_redirect(32'h300 + 32'(i * 16));
            tick();
            clr_redirect();
            repeat (2) tick();
        end
        @(negedge clk);
        check32("t6_count3", redirect_count, PERF ? 32'd3 : 32'd0);
        tick();
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_fl_addr.size() > 0) found = 1'b1;
        end
        check32("t6_setup_found", {31'b0, found}, 32'h1);
        set_redirect(32'h400);
        tick();
        clr_redirect();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        xfer_pc.delete();
        xfer_instr.delete();
        @(negedge clk);
        check32("t6_rst_count", redirect_count, 32'h0);
        check32("t6_rst_out_valid", {31'b0, out_valid}, 32'h0);
        check32("t6_rst_addr", imem_req_addr, RESET_PC);
        check32("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check32("t6_rst_out_pc", out_pc, 32'h0);
        wait_xfer("t6_after_reset", 1, 40);
        if (xfer_pc.size() >= 1) check32("t6_first_pc", xfer_pc[0], 32'h0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
